// File: rtl/dm_cache.sv
// dm_cache: direct-mapped read-only byte cache in front of a fixed XOR-pattern ROM
module dm_cache #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int INDEX_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [DATA_W-1:0] out
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS;
  localparam logic [DATA_W-1:0] ROM_KEY = DATA_W'(8'hA5);
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q [LINES];
  logic [TAG_W-1:0]      tag_d [LINES];
  logic [DATA_W-1:0]     data_q [LINES];
  logic [DATA_W-1:0]     data_d [LINES];
  logic                  hit_q, hit_d;
  logic [DATA_W-1:0]     out_q, out_d;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [DATA_W-1:0]     rom_data;
  logic                  is_hit;
  assign idx      = addr[INDEX_BITS-1:0];
  assign tag      = addr[ADDR_W-1:INDEX_BITS];
  assign rom_data = DATA_W'(addr) ^ ROM_KEY;
  assign is_hit   = valid_q[idx] && tag_q[idx] == tag;
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    hit_d   = is_hit;
    out_d   = is_hit ? data_q[idx] : rom_data;
    if (!is_hit) begin
      valid_d[idx] = 1'b1;
      tag_d[idx]   = tag;
      data_d[idx]  = rom_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      hit_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      hit_q   <= hit_d;
      out_q   <= out_d;
    end
  end
  assign hit = hit_q;
  assign out = out_q;
endmodule

// File: tb/tb_dm_cache.sv
// tb_dm_cache: table-driven and randomized scoreboard bench for dm_cache
module tb_dm_cache;
  typedef struct {
    logic       rst;
    logic [7:0] addr;
    logic       hit;
    logic [7:0] out;
  } vec_t;
  typedef struct {
    logic       hit;
    logic [7:0] out;
    string      name;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = '0;
  logic       hit;
  logic [7:0] out;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb [$];
  logic       m_valid [4];
  logic [5:0] m_tag [4];
  vec_t       tbl [$];
  dm_cache dut (.clk(clk), .rst(rst), .addr(addr), .hit(hit), .out(out));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model(input logic r, input logic [7:0] a, output logic h, output logic [7:0] o);
    logic [1:0] i;
    i = a[1:0];
    if (r) begin
      foreach (m_valid[k]) m_valid[k] = 1'b0;
      h = 1'b0;
      o = 8'h00;
    end else begin
      h = m_valid[i] && m_tag[i] == a[7:2];
      o = a ^ 8'hA5;
      m_valid[i] = 1'b1;
      m_tag[i] = a[7:2];
    end
  endtask
  task automatic step(input logic r, input logic [7:0] a, input logic use_exp,
                      input logic eh, input logic [7:0] eo, input string name);
    exp_t e;
    logic mh;
    logic [7:0] mo;
    @(negedge clk);
    rst = r;
    addr = a;
    model(r, a, mh, mo);
    e.hit = use_exp ? eh : mh;
    e.out = use_exp ? eo : mo;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check({e.name, ".hit"}, {7'd0, hit}, {7'd0, e.hit});
      check({e.name, ".out"}, out, e.out);
    end
  endtask
  initial begin
    logic [7:0] held;
    logic       held_hit;
    tbl = '{
      '{1'b1, 8'h00, 1'b0, 8'h00}, '{1'b1, 8'h00, 1'b0, 8'h00},
      '{1'b0, 8'h00, 1'b0, 8'hA5}, '{1'b0, 8'h01, 1'b0, 8'hA4},
      '{1'b0, 8'h02, 1'b0, 8'hA7}, '{1'b0, 8'h03, 1'b0, 8'hA6},
      '{1'b0, 8'h04, 1'b0, 8'hA1}, '{1'b0, 8'h00, 1'b0, 8'hA5},
      '{1'b0, 8'h01, 1'b1, 8'hA4}, '{1'b0, 8'h37, 1'b0, 8'h92},
      '{1'b0, 8'h37, 1'b1, 8'h92}, '{1'b0, 8'hFF, 1'b0, 8'h5A},
      '{1'b0, 8'h03, 1'b0, 8'hA6}, '{1'b0, 8'hFF, 1'b0, 8'h5A},
      '{1'b0, 8'h00, 1'b1, 8'hA5}, '{1'b0, 8'h01, 1'b1, 8'hA4},
      '{1'b0, 8'h02, 1'b1, 8'hA7}, '{1'b0, 8'h03, 1'b0, 8'hA6},
      '{1'b1, 8'h03, 1'b0, 8'h00}, '{1'b0, 8'h01, 1'b0, 8'hA4},
      '{1'b0, 8'h01, 1'b1, 8'hA4}
    };
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].addr, 1'b1, tbl[i].hit, tbl[i].out, $sformatf("vec%0d", i));
    step(1'b0, 8'h10, 1'b1, 1'b0, 8'hB5, "hold");
    held = out;
    held_hit = hit;
    addr = 8'h99;
    #3;
    check("hold.out", out, held);
    check("hold.hit", {7'd0, hit}, {7'd0, held_hit});
    step(1'b0, 8'h10, 1'b1, 1'b1, 8'hB5, "hold_rehit");
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 40) == 0), 8'($urandom_range(0, 15) | ($urandom_range(0, 1) << 7)),
           1'b0, 1'b0, 8'h00, $sformatf("rnd%0d", i));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_cache.md
Name: dm_cache

Overview:
Read-only direct-mapped cache of single-byte lines in front of an internal 256x8 backing ROM. Each clock cycle one 8-bit address is looked up, the hit/miss result and read data are registered, and the line is refilled on a miss. It is a small lookup-acceleration block driven by a free-running address stream, with no request/valid handshake.

Parameters:
- ADDR_W, 8, address width; the backing ROM has 2^ADDR_W entries.
- DATA_W, 8, data width of a ROM entry and of a cache line.
- INDEX_BITS, 2, number of index bits; the cache has 2^INDEX_BITS lines (default 4).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- addr  input  ADDR_W  lookup address, sampled every rising edge.
- hit  output  1  registered hit flag for the address sampled at the last edge.
- out  output  DATA_W  registered read data for the address sampled at the last edge.

Behaviour:
- Reset is synchronous and active-high (already decided). On a clk edge with rst=1:
  - all valid bits clear to 0;
  - hit=0 and out=0;
  - tag and data arrays need not be cleared;
  - rst has priority over any lookup in the same cycle.
- Address split:
  - index = addr[INDEX_BITS-1:0];
  - tag = addr[ADDR_W-1:INDEX_BITS], 6 bits at default.
- Storage per line: valid (1 bit), tag (ADDR_W-INDEX_BITS bits), data (DATA_W bits).
- Backing ROM contents are fixed: ROM[a] = a XOR 8'hA5. The generic form is a XOR a constant of DATA_W bits, with the low 8 bits equal to 8'hA5. The ROM is read combinationally, with zero latency.
- Lookup happens on every rising edge with rst=0.
  - Hit condition: valid[index]=1 and tag[index]==tag.
  - On a hit: hit<=1 and out<=data[index]. Arrays are unchanged.
  - On a miss: hit<=0 and out<=ROM[addr]. The line is refilled in the same edge: valid[index]<=1, tag[index]<=tag, data[index]<=ROM[addr].
- Latency is 1 cycle. hit and out reflect the address present at the preceding rising edge and hold until the next edge.
- Changes to addr between edges have no effect.
- Replacement is direct-mapped only: a miss always overwrites the single line selected by index, evicting any previous tag.
- Back-to-back accesses:
  - The same address on consecutive edges gives a miss then a hit, because the refill is visible on the next edge.
  - Data returned by a hit always equals ROM[addr], so out is address-correct whether the access hits or misses.
- Boundaries:
  - Address 8'hFF maps to index 3 with tag 6'h3F.
  - Address 8'h00 after reset is always a miss.
  - There is no write path and no coherency concern.
- out and hit are the only outputs. No X may appear on them after the first post-reset edge.

Test Plan:
- Reset: hold rst=1 for 2 edges -> hit=0, out=0. Release, then apply addr=0 -> after the edge hit=0, out=8'hA5 (cold miss).
- Cold fill: from reset, apply addr 0,1,2,3 on consecutive edges -> all misses; out = A5, A4, A7, A6.
- Conflict eviction: after the cold fill, apply addr=4, then 0, then 1:
  - addr=4 -> miss, out=A1; it evicts line 0;
  - addr=0 -> miss, out=A5;
  - addr=1 -> hit=1, out=A4.
- Repeat hit: apply addr=8'h37 twice on consecutive edges -> first edge miss with out=8'h92, second edge hit=1 with out=8'h92.
- Upper boundary: apply addr=8'hFF, then 8'h03, then 8'hFF (all index 3) -> three misses; out = 5A, A6, 5A.
- Reset mid-operation: fill lines with addr 0..3, assert rst for 1 edge, then apply addr=1 -> hit=0, out=A4 (valid bits were cleared).
